// File: rtl/iddmm_share_arbiter_pkg.sv
// Shared types for the iddmm engine-sharing arbiter: write-bus bundle, FSM states, helpers.
package iddmm_pkg;

    localparam int unsigned IDDMM_K = 128;
    localparam int unsigned IDDMM_N = 32;
    localparam int unsigned AW      = $clog2(IDDMM_N);

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        RUN
    } arb_state_e;

    typedef struct packed {
        logic [2:0]         ena;
        logic [AW-1:0]      addr;
        logic [IDDMM_K-1:0] x;
        logic [IDDMM_K-1:0] y;
        logic [IDDMM_K-1:0] m;
        logic [IDDMM_K-1:0] m1;
    } iddmm_wr_t;

    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned num);
        return (idx + 1 >= num) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/iddmm_share_arbiter_arb.sv
// One-hot request arbiter: round-robin from ptr, or fixed lowest-index priority.
module rr_onehot_arb #(
    parameter int unsigned NUM  = 2,
    parameter string       MODE = "RR",
    localparam int unsigned PW  = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic [NUM-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NUM-1:0] grant
);

    logic [NUM-1:0] req_hi;
    logic [NUM-1:0] pick_src;

    always_comb begin
        // requests at or above ptr win first; wrap to the full vector otherwise
        req_hi = req & ({NUM{1'b1}} << ptr);
        if (MODE == "RR" && req_hi != '0) begin
            pick_src = req_hi;
        end else begin
            pick_src = req;
        end
        grant = pick_src & (~pick_src + NUM'(1));
    end

endmodule

// File: rtl/iddmm_share_arbiter.sv
// Shares one iddmm_top engine among NUM_CLIENTS front-ends; ownership is locked from grant
// until the engine finishes its task, and foreign traffic is dropped and flagged.
module iddmm_share_arbiter
    import iddmm_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 2,
    parameter int unsigned K           = 128,
    parameter int unsigned N           = 32,
    parameter string       ARB_MODE    = "RR",
    localparam int unsigned ADDR_W     = $clog2(N),
    localparam int unsigned IW         = $clog2(NUM_CLIENTS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CLIENTS-1:0]        cl_acq,
    output logic [NUM_CLIENTS-1:0]        cl_own,
    input  logic [NUM_CLIENTS*3-1:0]      cl_wr_ena,
    input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_wr_addr,
    input  logic [NUM_CLIENTS*K-1:0]      cl_wr_x,
    input  logic [NUM_CLIENTS*K-1:0]      cl_wr_y,
    input  logic [NUM_CLIENTS*K-1:0]      cl_wr_m,
    input  logic [NUM_CLIENTS*K-1:0]      cl_wr_m1,
    input  logic [NUM_CLIENTS-1:0]        cl_task_req,
    output logic [NUM_CLIENTS-1:0]        cl_task_grant,
    output logic [NUM_CLIENTS-1:0]        cl_task_end,
    output logic [NUM_CLIENTS*K-1:0]      cl_task_res,
    output logic [2:0]                    e_wr_ena,
    output logic [ADDR_W-1:0]             e_wr_addr,
    output logic [K-1:0]                  e_wr_x,
    output logic [K-1:0]                  e_wr_y,
    output logic [K-1:0]                  e_wr_m,
    output logic [K-1:0]                  e_wr_m1,
    output logic                          e_task_req,
    input  logic                          e_task_grant,
    input  logic                          e_task_end,
    input  logic [K-1:0]                  e_task_res,
    output logic                          err_intrude,
    output logic                          err_orphan,
    input  logic                          err_clr
);

    typedef struct packed {
        logic [2:0]        ena;
        logic [ADDR_W-1:0] addr;
        logic [K-1:0]      x;
        logic [K-1:0]      y;
        logic [K-1:0]      m;
        logic [K-1:0]      m1;
    } wr_bus_t;

    arb_state_e             state_q;
    logic [IW-1:0]          owner_q;
    logic [IW-1:0]          ptr_q;
    logic [NUM_CLIENTS-1:0] own_q;
    logic                   err_intrude_q;
    logic                   err_orphan_q;

    logic [NUM_CLIENTS-1:0] win_onehot;
    logic [IW-1:0]          win_idx;
    wr_bus_t                cl_bus [NUM_CLIENTS];
    wr_bus_t                e_bus;
    logic [NUM_CLIENTS-1:0] sel;
    logic [NUM_CLIENTS-1:0] intrude_vec;
    logic                   active;
    logic                   in_run;
    logic                   owner_acq;
    logic                   owner_req;
    logic                   set_intrude;
    logic                   set_orphan;

    assign active    = (state_q != IDLE);
    assign in_run    = (state_q == RUN);
    assign owner_acq = cl_acq[owner_q];
    assign owner_req = cl_task_req[owner_q];

    for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_client
        assign cl_bus[c] = {cl_wr_ena[3*c +: 3], cl_wr_addr[ADDR_W*c +: ADDR_W],
                            cl_wr_x[K*c +: K], cl_wr_y[K*c +: K],
                            cl_wr_m[K*c +: K], cl_wr_m1[K*c +: K]};
        assign sel[c]         = active && (owner_q == IW'(c));
        // in IDLE nobody owns the engine, so any traffic counts as intrusion
        assign intrude_vec[c] = !sel[c] && (cl_task_req[c] || (cl_wr_ena[3*c +: 3] != 3'b000));
        assign cl_task_grant[c]       = sel[c] && e_task_grant;
        assign cl_task_end[c]         = sel[c] && in_run && e_task_end;
        assign cl_task_res[K*c +: K]  = sel[c] ? e_task_res : '0;
    end

    assign set_intrude = |intrude_vec;
    assign set_orphan  = e_task_end && !in_run;

    // engine bus is steered only from the registered owner index
    assign e_bus      = active ? cl_bus[owner_q] : '0;
    assign e_wr_ena   = e_bus.ena;
    assign e_wr_addr  = e_bus.addr;
    assign e_wr_x     = e_bus.x;
    assign e_wr_y     = e_bus.y;
    assign e_wr_m     = e_bus.m;
    assign e_wr_m1    = e_bus.m1;
    assign e_task_req = active && owner_req;

    rr_onehot_arb #(
        .NUM  (NUM_CLIENTS),
        .MODE (ARB_MODE)
    ) u_arb (
        .req   (cl_acq),
        .ptr   (ptr_q),
        .grant (win_onehot)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (win_onehot[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            owner_q       <= '0;
            ptr_q         <= '0;
            own_q         <= '0;
            err_intrude_q <= 1'b0;
            err_orphan_q  <= 1'b0;
        end else begin
            if (set_intrude) begin
                err_intrude_q <= 1'b1;
            end else if (err_clr) begin
                err_intrude_q <= 1'b0;
            end
            if (set_orphan) begin
                err_orphan_q <= 1'b1;
            end else if (err_clr) begin
                err_orphan_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // first IDLE cycle after a release only drops cl_own; arbitration waits
                    if (own_q != '0) begin
                        own_q <= '0;
                    end else if (cl_acq != '0) begin
                        state_q <= OWNED;
                        owner_q <= win_idx;
                        own_q   <= win_onehot;
                        ptr_q   <= IW'(wrap_inc(32'(win_idx), NUM_CLIENTS));
                    end
                end
                OWNED: begin
                    if (owner_req) begin
                        state_q <= RUN;
                    end else if (!owner_acq) begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    // the engine cannot be aborted: release waits for task_end
                    if (e_task_end) begin
                        state_q <= owner_acq ? OWNED : IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cl_own      = own_q;
    assign err_intrude = err_intrude_q;
    assign err_orphan  = err_orphan_q;

endmodule

// File: tb/tb_iddmm_share_arbiter.sv
// Bench for iddmm_share_arbiter: RR and FIXED instances on shared stimulus, each checked
// every cycle against a behavioural ownership model, plus directed literal expectations.
module tb_iddmm_share_arbiter;

    localparam int NC = 3;
    localparam int K  = 32;
    localparam int N  = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [NC-1:0]    cl_acq, cl_task_req;
    logic [NC*3-1:0]  cl_wr_ena;
    logic [NC*AW-1:0] cl_wr_addr;
    logic [NC*K-1:0]  cl_wr_x, cl_wr_y, cl_wr_m, cl_wr_m1;
    logic             e_task_grant, e_task_end, err_clr;
    logic [K-1:0]     e_task_res;

    logic [NC-1:0]   o_own [2];
    logic [NC-1:0]   o_grant [2];
    logic [NC-1:0]   o_end [2];
    logic [NC*K-1:0] o_res [2];
    logic [2:0]      o_ena [2];
    logic [AW-1:0]   o_addr [2];
    logic [K-1:0]    o_x [2];
    logic [K-1:0]    o_y [2];
    logic [K-1:0]    o_m [2];
    logic [K-1:0]    o_m1 [2];
    logic            o_req [2];
    logic            o_eint [2];
    logic            o_eorp [2];

    iddmm_share_arbiter #(.NUM_CLIENTS(NC), .K(K), .N(N), .ARB_MODE("RR")) dut_rr (
        .clk(clk), .rst_n(rst_n), .cl_acq(cl_acq), .cl_own(o_own[0]),
        .cl_wr_ena(cl_wr_ena), .cl_wr_addr(cl_wr_addr), .cl_wr_x(cl_wr_x), .cl_wr_y(cl_wr_y),
        .cl_wr_m(cl_wr_m), .cl_wr_m1(cl_wr_m1), .cl_task_req(cl_task_req),
        .cl_task_grant(o_grant[0]), .cl_task_end(o_end[0]), .cl_task_res(o_res[0]),
        .e_wr_ena(o_ena[0]), .e_wr_addr(o_addr[0]), .e_wr_x(o_x[0]), .e_wr_y(o_y[0]),
        .e_wr_m(o_m[0]), .e_wr_m1(o_m1[0]), .e_task_req(o_req[0]),
        .e_task_grant(e_task_grant), .e_task_end(e_task_end), .e_task_res(e_task_res),
        .err_intrude(o_eint[0]), .err_orphan(o_eorp[0]), .err_clr(err_clr)
    );

    iddmm_share_arbiter #(.NUM_CLIENTS(NC), .K(K), .N(N), .ARB_MODE("FIXED")) dut_fx (
        .clk(clk), .rst_n(rst_n), .cl_acq(cl_acq), .cl_own(o_own[1]),
        .cl_wr_ena(cl_wr_ena), .cl_wr_addr(cl_wr_addr), .cl_wr_x(cl_wr_x), .cl_wr_y(cl_wr_y),
        .cl_wr_m(cl_wr_m), .cl_wr_m1(cl_wr_m1), .cl_task_req(cl_task_req),
        .cl_task_grant(o_grant[1]), .cl_task_end(o_end[1]), .cl_task_res(o_res[1]),
        .e_wr_ena(o_ena[1]), .e_wr_addr(o_addr[1]), .e_wr_x(o_x[1]), .e_wr_y(o_y[1]),
        .e_wr_m(o_m[1]), .e_wr_m1(o_m1[1]), .e_task_req(o_req[1]),
        .e_task_grant(e_task_grant), .e_task_end(e_task_end), .e_task_res(e_task_res),
        .err_intrude(o_eint[1]), .err_orphan(o_eorp[1]), .err_clr(err_clr)
    );

    // Model: phase 0 = nobody owns, 1 = owned, 2 = task in flight
    int            ph [2];
    int            ow [2];
    int            ptr [2];
    logic [NC-1:0] own [2];
    logic          ei [2];
    logic          eo [2];
    int            n_pass = 0;
    int            n_total = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic int pick(int m, int p, logic [NC-1:0] req);
        int start = (m == 0) ? p : 0;
        for (int i = 0; i < NC; i++) begin
            if (req[(start + i) % NC]) return (start + i) % NC;
        end
        return -1;
    endfunction

    function automatic int enc(logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v == (NC'(1) << i)) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            ph[m] = 0; ow[m] = 0; ptr[m] = 0; own[m] = '0; ei[m] = 1'b0; eo[m] = 1'b0;
        end
    endtask

    task automatic step(int m);
        bit act = (ph[m] != 0);
        bit intr = 1'b0;
        int w;
        for (int c = 0; c < NC; c++) begin
            if ((!act || c != ow[m]) && (cl_task_req[c] || cl_wr_ena[3*c +: 3] != 3'b0)) intr = 1'b1;
        end
        ei[m] = intr ? 1'b1 : (err_clr ? 1'b0 : ei[m]);
        eo[m] = (e_task_end && ph[m] != 2) ? 1'b1 : (err_clr ? 1'b0 : eo[m]);
        case (ph[m])
            0: begin
                if (own[m] != '0) begin
                    own[m] = '0;
                end else if (cl_acq != '0) begin
                    w = pick(m, ptr[m], cl_acq);
                    ow[m] = w; own[m] = NC'(1) << w; ptr[m] = (w + 1) % NC; ph[m] = 1;
                end
            end
            1: begin
                if (cl_task_req[ow[m]]) ph[m] = 2;
                else if (!cl_acq[ow[m]]) ph[m] = 0;
            end
            default: begin
                if (e_task_end) ph[m] = cl_acq[ow[m]] ? 1 : 0;
            end
        endcase
    endtask

    task automatic check_model(int m);
        bit    act = (ph[m] != 0);
        int    o = ow[m];
        string t = (m == 0) ? "rr" : "fx";
        chk({t, " cl_own"}, 128'(o_own[m]), 128'(own[m]));
        chk({t, " e_wr_ena"}, 128'(o_ena[m]), act ? 128'(cl_wr_ena[3*o +: 3]) : 128'(0));
        chk({t, " e_wr_addr"}, 128'(o_addr[m]), act ? 128'(cl_wr_addr[AW*o +: AW]) : 128'(0));
        chk({t, " e_wr_x"}, 128'(o_x[m]), act ? 128'(cl_wr_x[K*o +: K]) : 128'(0));
        chk({t, " e_wr_y"}, 128'(o_y[m]), act ? 128'(cl_wr_y[K*o +: K]) : 128'(0));
        chk({t, " e_wr_m"}, 128'(o_m[m]), act ? 128'(cl_wr_m[K*o +: K]) : 128'(0));
        chk({t, " e_wr_m1"}, 128'(o_m1[m]), act ? 128'(cl_wr_m1[K*o +: K]) : 128'(0));
        chk({t, " e_task_req"}, 128'(o_req[m]), act ? 128'(cl_task_req[o]) : 128'(0));
        chk({t, " cl_task_grant"}, 128'(o_grant[m]),
            (act && e_task_grant) ? (128'(1) << o) : 128'(0));
        chk({t, " cl_task_end"}, 128'(o_end[m]),
            (ph[m] == 2 && e_task_end) ? (128'(1) << o) : 128'(0));
        chk({t, " cl_task_res"}, 128'(o_res[m]), act ? (128'(e_task_res) << (K * o)) : 128'(0));
        chk({t, " err_intrude"}, 128'(o_eint[m]), 128'(ei[m]));
        chk({t, " err_orphan"}, 128'(o_eorp[m]), 128'(eo[m]));
    endtask

    task automatic tick();
        @(negedge clk);
        check_model(0);
        check_model(1);
        @(posedge clk);
        if (rst_n) begin
            step(0);
            step(1);
        end
        #1;
        cl_wr_addr = NC*AW'({$urandom, $urandom});
        cl_wr_x    = {$urandom, $urandom, $urandom};
        cl_wr_y    = {$urandom, $urandom, $urandom};
        cl_wr_m    = {$urandom, $urandom, $urandom};
        cl_wr_m1   = {$urandom, $urandom, $urandom};
        e_task_res = $urandom;
    endtask

    task automatic quiet();
        cl_acq = '0; cl_task_req = '0; cl_wr_ena = '0;
        e_task_grant = 1'b0; e_task_end = 1'b0; err_clr = 1'b0;
    endtask

    // async reset applied mid-cycle; everything must read zero before the next edge
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("reset cl_own", 128'(o_own[m]), 128'(0));
            chk("reset e_wr_ena", 128'(o_ena[m]), 128'(0));
            chk("reset e_task_req", 128'(o_req[m]), 128'(0));
            chk("reset cl_task_res", 128'(o_res[m]), 128'(0));
            chk("reset errs", 128'({o_eint[m], o_eorp[m]}), 128'(0));
        end
        quiet();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int w;
    int waited;
    int exp_order[4] = '{0, 1, 2, 0};
    logic [NC-1:0] acq_nx;

    initial begin
        rst_n = 1'b0;
        quiet();
        model_reset();
        cl_wr_addr = '0; cl_wr_x = '0; cl_wr_y = '0; cl_wr_m = '0; cl_wr_m1 = '0;
        e_task_res = '0;
        tick();
        do_reset();

        // Round-robin fairness with everyone requesting
        cl_acq = 3'b111;
        for (int r = 0; r < 4; r++) begin
            waited = 0;
            while (o_own[0] == '0 && waited < 8) begin
                tick();
                waited++;
            end
            w = enc(o_own[0]);
            chk("rr grant order", 128'(w), 128'(exp_order[r]));
            if (w < 0) w = 0;
            cl_wr_ena = 9'(3'b001) << (3 * w);
            tick();
            cl_wr_ena = '0;
            cl_task_req = NC'(1) << w;
            tick();
            cl_task_req = '0;
            e_task_end = 1'b1;
            cl_acq[w] = 1'b0;
            tick();
            e_task_end = 1'b0;
            tick();
            cl_wr_ena = 9'(3'b001) << (3 * w);
            #1;
            chk("rr gap cl_own", 128'(o_own[0]), 128'(0));
            chk("rr gap e_wr_ena", 128'(o_ena[0]), 128'(0));
            cl_wr_ena = '0;
            cl_acq[w] = 1'b1;
        end

        // FIXED: lowest index wins, next client granted after the idle gap
        do_reset();
        cl_acq = 3'b110;
        tick();
        #1;
        chk("fx grant 110", 128'(o_own[1]), 128'(3'b010));
        chk("rr grant 110", 128'(o_own[0]), 128'(3'b010));
        cl_acq = 3'b100;
        tick();
        #1 chk("fx release held", 128'(o_own[1]), 128'(3'b010));
        tick();
        #1 chk("fx idle gap", 128'(o_own[1]), 128'(3'b000));
        tick();
        #1 chk("fx second grant", 128'(o_own[1]), 128'(3'b100));

        // Intrusion while client 0 runs
        do_reset();
        cl_acq = 3'b001;
        tick();
        cl_task_req = 3'b001;
        tick();
        cl_task_req = 3'b100;
        cl_wr_ena = 9'b001_000_000;
        #1;
        chk("intrude e_task_req", 128'(o_req[0]), 128'(0));
        chk("intrude e_wr_ena", 128'(o_ena[0]), 128'(0));
        tick();
        cl_task_req = '0;
        cl_wr_ena = '0;
        #1 chk("intrude flag", 128'(o_eint[0]), 128'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1 chk("intrude cleared", 128'(o_eint[0]), 128'(0));

        // Early release during RUN, then an orphan end
        cl_acq = 3'b000;
        tick();
        #1 chk("early release held", 128'(o_own[0]), 128'(3'b001));
        e_task_end = 1'b1;
        e_task_res = 32'h1234_5678;
        #1;
        chk("early release res", 128'(o_res[0]), 128'(96'h1234_5678));
        chk("early release end", 128'(o_end[0]), 128'(3'b001));
        tick();
        e_task_end = 1'b0;
        #1 chk("release cycle own", 128'(o_own[0]), 128'(3'b001));
        tick();
        #1 chk("released own", 128'(o_own[0]), 128'(0));
        e_task_end = 1'b1;
        #1 chk("orphan end dropped", 128'(o_end[0]), 128'(0));
        tick();
        e_task_end = 1'b0;
        #1 chk("orphan flag", 128'(o_eorp[0]), 128'(1));

        // Reset in the middle of a task, then pointer restarts at 0
        do_reset();
        cl_acq = 3'b010;
        tick();
        cl_task_req = 3'b010;
        tick();
        cl_wr_ena = 9'b000_001_000;
        do_reset();
        cl_acq = 3'b110;
        tick();
        #1;
        chk("post-reset rr grant", 128'(o_own[0]), 128'(3'b010));
        chk("post-reset fx grant", 128'(o_own[1]), 128'(3'b010));

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            acq_nx = cl_acq;
            for (int c = 0; c < NC; c++) if ($urandom_range(7) == 0) acq_nx[c] = ~acq_nx[c];
            cl_acq = acq_nx;
            cl_task_req = '0;
            cl_wr_ena = '0;
            for (int c = 0; c < NC; c++) begin
                if (ph[0] != 0 && c == ow[0]) begin
                    cl_task_req[c] = ($urandom_range(5) == 0);
                    if ($urandom_range(1) == 0) cl_wr_ena[3*c +: 3] = 3'($urandom);
                end else begin
                    cl_task_req[c] = ($urandom_range(39) == 0);
                    if ($urandom_range(39) == 0) cl_wr_ena[3*c +: 3] = 3'($urandom_range(7, 1));
                end
            end
            e_task_grant = ($urandom_range(3) == 0);
            e_task_end = ($urandom_range(7) == 0);
            err_clr = ($urandom_range(15) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
